heap_host_if: RTL and testbench
===============================

// Module: heap_host_if
// PURPOSE
//  Host-side initiator for the heap engine's start/op/key/done command port.
//  Accepts push/pop commands on a valid/ready port, issues each to the engine,
//  waits for done and captures the engine's first dumped word (heap root) and count.
//  Returns one response per command.
//  Keeps a shadow element count. Rejects pop-on-empty and push-on-full locally,
//  without touching the engine.
// PARAMETERS
//  KEY_W    32    key / data width
//  IDX_W    10    count width; capacity = 2**IDX_W - 1 elements
//  TIMEOUT  4096  max cycles waited for hp_done before abort (>=2)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_op       in   1      0 = push, 1 = pop
//  cmd_key      in   KEY_W  push key (ignored for pop)
//  hp_start     out  1      one-cycle start pulse to engine
//  hp_op        out  1      op to engine, stable from start until done
//  hp_key       out  KEY_W  key to engine, stable from start until done
//  hp_done      in   1      engine completion pulse
//  hp_n         in   IDX_W  engine element count
//  hp_data      in   KEY_W  engine dump word; valid the cycle after hp_done (root)
//  rsp_valid    out  1      response valid, held until rsp_ready
//  rsp_ready    in   1      response consumed
//  rsp_top      out  KEY_W  captured root after op (0 if not issued)
//  rsp_n        out  IDX_W  engine count after op (shadow count if not issued)
//  rsp_ok       out  1      op issued, done seen, hp_n == updated shadow count
//  rsp_empty    out  1      pop rejected, shadow count was 0
//  rsp_full     out  1      push rejected, shadow count was 2**IDX_W-1
//  rsp_timeout  out  1      engine gave no hp_done within TIMEOUT cycles
// BEHAVIOUR
//  Reset: state IDLE; shadow count 0. All outputs 0 except cmd_ready = 1.
//  Reset mid-operation aborts the op; no response is produced.
//  FSM states: IDLE, ISSUE, WAIT_DONE, CAPTURE, RESP.
//  - IDLE: cmd_ready=1. On accept, latch op/key into hp_op/hp_key.
//    Pop with count 0 -> RESP, rsp_empty=1.
//    Push with count max -> RESP, rsp_full=1.
//    Otherwise -> ISSUE.
//  - ISSUE: hp_start=1 for exactly this cycle. Clear timer. -> WAIT_DONE.
//  - WAIT_DONE: timer++.
//    hp_done=1 -> CAPTURE.
//    Timer reaches TIMEOUT-1 without done -> RESP, rsp_timeout=1, count unchanged.
//  - CAPTURE: rsp_top<=hp_data; rsp_n<=hp_n.
//    count <= count+1 on push, count-1 on pop.
//    rsp_ok <= (hp_n == new count). -> RESP.
//  - RESP: rsp_valid=1; all rsp_* held stable until rsp_ready.
//    On rsp_ready: rsp_valid <= 0 and all rsp_* flags cleared -> IDLE.
//  cmd_ready=0 in every state except IDLE: one command in flight, no pipelining.
//  Exactly one rsp_* flag (ok/empty/full/timeout) may be 1 per response.
//  rsp_ok=0 with no other flag set means a count mismatch.
//  hp_done seen outside WAIT_DONE is ignored.
//  Latency: local reject gives rsp_valid 1 cycle after accept.
//  Issued command: rsp_valid 2 cycles after the hp_done cycle.
//  Count arithmetic is IDX_W-bit. Wrap cannot occur because of the empty/full rejects.
// CONFIGURATION
//  HEAP_HOST_STATS_EN defined: adds outputs stat_push, stat_pop, stat_err (32b each).
//    stat_push / stat_pop: completed ok pushes / pops.
//    stat_err: responses with any of empty/full/timeout, or an ok-less mismatch.
//    Counters saturate at all-ones and are cleared by reset.
//  Not defined: the ports and counter logic are absent.
// TESTING
//  1 Reset 3 cycles -> cmd_ready=1; hp_start=0; rsp_valid=0; shadow count 0.
//  2 Push 5,9,3 against a behavioural engine model
//    -> responses rsp_top 5,9,9; rsp_n 1,2,3; rsp_ok=1 each.
//  3 Pop on empty -> rsp_empty=1, rsp_valid 1 cycle after accept, hp_start never high.
//  4 Engine holds hp_done low -> rsp_timeout=1 exactly TIMEOUT+1 cycles after start;
//    count unchanged.
//  5 rsp_ready low 10 cycles -> rsp_* stable and cmd_ready=0 throughout.
//    Reset asserted in WAIT_DONE -> IDLE, count 0, no response.
//  6 STATS_EN: 3 push, 1 pop, 1 empty pop -> stat_push=3, stat_pop=1, stat_err=1.

Source files
------------

// File: rtl/heap_host_if.sv
// heap_host_if: host-side initiator for heap engine push/pop commands; `HEAP_HOST_STATS_EN adds op/error counters
module heap_host_if #(
  parameter int KEY_W   = 32,
  parameter int IDX_W   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  output logic             hp_start,
  output logic             hp_op,
  output logic [KEY_W-1:0] hp_key,
  input  logic             hp_done,
  input  logic [IDX_W-1:0] hp_n,
  input  logic [KEY_W-1:0] hp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [KEY_W-1:0] rsp_top,
  output logic [IDX_W-1:0] rsp_n,
  output logic             rsp_ok,
  output logic             rsp_empty,
  output logic             rsp_full,
  output logic             rsp_timeout
`ifdef HEAP_HOST_STATS_EN
  ,
  output logic [31:0]      stat_push,
  output logic [31:0]      stat_pop,
  output logic [31:0]      stat_err
`endif
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] MAX = '1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, CAPTURE, RESP} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic op_q, op_d, ok_q, ok_d, empty_q, empty_d, full_q, full_d, to_q, to_d;
  logic [KEY_W-1:0] key_q, key_d, top_q, top_d;
  // next state, shadow count, timer and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    tmr_d   = tmr_q;
    op_d    = op_q;
    key_d   = key_q;
    top_d   = top_q;
    ok_d    = ok_q;
    empty_d = empty_q;
    full_d  = full_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d  = cmd_op;
        key_d = cmd_key;
        n_d   = cnt_q;
        empty_d = cmd_op && cnt_q == '0;
        full_d  = !cmd_op && cnt_q == MAX;
        state_d = (empty_d || full_d) ? RESP : ISSUE;
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (hp_done) state_d = CAPTURE;
        else if (tmr_q == TLAST) begin
          to_d    = 1'b1;
          n_d     = cnt_q;
          state_d = RESP;
        end else tmr_d = tmr_q + 1'b1;
      CAPTURE: begin
        top_d   = hp_data;
        n_d     = hp_n;
        cnt_d   = op_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
        ok_d    = hp_n == cnt_d;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        top_d   = '0;
        n_d     = '0;
        ok_d    = 1'b0;
        empty_d = 1'b0;
        full_d  = 1'b0;
        to_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      tmr_q   <= '0;
      op_q    <= 1'b0;
      key_q   <= '0;
      top_q   <= '0;
      ok_q    <= 1'b0;
      empty_q <= 1'b0;
      full_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      key_q   <= key_d;
      top_q   <= top_d;
      ok_q    <= ok_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      to_q    <= to_d;
    end
  end
  assign cmd_ready   = state_q == IDLE;
  assign hp_start    = state_q == ISSUE;
  assign rsp_valid   = state_q == RESP;
  assign hp_op       = op_q;
  assign hp_key      = key_q;
  assign rsp_top     = top_q;
  assign rsp_n       = n_q;
  assign rsp_ok      = ok_q;
  assign rsp_empty   = empty_q;
  assign rsp_full    = full_q;
  assign rsp_timeout = to_q;
`ifdef HEAP_HOST_STATS_EN
  logic [31:0] stat_push_q, stat_pop_q, stat_err_q;
  logic fire;
  assign fire = rsp_valid && rsp_ready;
  // saturating counters bumped as each response is consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_push_q <= '0;
      stat_pop_q  <= '0;
      stat_err_q  <= '0;
    end else if (fire) begin
      if (ok_q && !op_q && stat_push_q != '1) stat_push_q <= stat_push_q + 32'd1;
      if (ok_q && op_q && stat_pop_q != '1) stat_pop_q <= stat_pop_q + 32'd1;
      if (!ok_q && stat_err_q != '1) stat_err_q <= stat_err_q + 32'd1;
    end
  end
  assign stat_push = stat_push_q;
  assign stat_pop  = stat_pop_q;
  assign stat_err  = stat_err_q;
`endif
endmodule

// File: tb/tb_heap_host_if.sv
// tb_heap_host_if: randomized and directed checks of heap_host_if against a queue-based engine and response model
module tb_heap_host_if;
  localparam int KEY_W = 32, IDX_W = 3, TIMEOUT = 16, CAP = 7;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, hp_done = 1'b0, rsp_ready = 1'b0;
  logic [KEY_W-1:0] cmd_key = '0, hp_data = '0;
  logic [IDX_W-1:0] hp_n = '0;
  logic cmd_ready, hp_start, hp_op, rsp_valid, rsp_ok, rsp_empty, rsp_full, rsp_timeout;
  logic [KEY_W-1:0] hp_key, rsp_top;
  logic [IDX_W-1:0] rsp_n;
`ifdef HEAP_HOST_STATS_EN
  logic [31:0] stat_push, stat_pop, stat_err;
`endif
  int checks = 0, errors = 0;
  int ref_cnt = 0, ref_push = 0, ref_pop = 0, ref_err = 0;
  int unsigned eng_q[$];

  heap_host_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .hp_start(hp_start), .hp_op(hp_op),
    .hp_key(hp_key), .hp_done(hp_done), .hp_n(hp_n), .hp_data(hp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_top(rsp_top), .rsp_n(rsp_n),
    .rsp_ok(rsp_ok), .rsp_empty(rsp_empty), .rsp_full(rsp_full), .rsp_timeout(rsp_timeout)
`ifdef HEAP_HOST_STATS_EN
    , .stat_push(stat_push), .stat_pop(stat_pop), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned eng_max();
    int unsigned m = 0;
    foreach (eng_q[i]) if (eng_q[i] > m) m = eng_q[i];
    return m;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    cmd_valid = 1'b0;
    hp_done = 1'b0;
    rsp_ready = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    ref_cnt = 0; ref_push = 0; ref_pop = 0; ref_err = 0;
    eng_q.delete();
  endtask

  // one command end to end: engine acts as the queue model, expectations follow the host rules
  task automatic send(input bit op, input logic [KEY_W-1:0] key, input int dly,
                      input bit nodone, input bit badn, input int hold);
    logic [KEY_W-1:0] e_top;
    logic [IDX_W-1:0] e_n;
    bit e_ok, e_empty, e_full, e_to;
    int k;
    e_top = '0; e_n = '0; e_ok = 0; e_empty = 0; e_full = 0; e_to = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key;
    tick();
    cmd_valid = 1'b0; cmd_key = $urandom;
    if (op && ref_cnt == 0) begin
      e_empty = 1; e_n = IDX_W'(ref_cnt);
      chk("rej_nostart", hp_start, 0);
    end else if (!op && ref_cnt == CAP) begin
      e_full = 1; e_n = IDX_W'(ref_cnt);
      chk("rej_nostart", hp_start, 0);
    end else begin
      chk("start", hp_start, 1);
      chk("hp_op", hp_op, op);
      if (!op) chk("hp_key", hp_key, key);
      if (nodone) begin
        k = 0;
        while (!rsp_valid && k < 100) begin tick(); k++; end
        chk("timeout_lat", k, TIMEOUT + 1);
        e_to = 1; e_n = IDX_W'(ref_cnt);
      end else begin
        tick();
        chk("start_pulse", hp_start, 0);
        repeat (dly) tick();
        chk("wait_novalid", rsp_valid, 0);
        hp_done = 1'b1;
        tick();
        hp_done = 1'b0;
        if (op) begin
          foreach (eng_q[i]) if (eng_q[i] == eng_max()) begin eng_q.delete(i); break; end
        end else eng_q.push_back(key);
        e_top = eng_max();
        e_n = IDX_W'(eng_q.size() + int'(badn));
        hp_data = e_top; hp_n = e_n;
        chk("capture_novalid", rsp_valid, 0);
        tick();
        hp_data = $urandom; hp_n = IDX_W'($urandom);
        ref_cnt = op ? ref_cnt - 1 : ref_cnt + 1;
        e_ok = int'(e_n) == ref_cnt;
      end
    end
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_vr", {rsp_valid, cmd_ready}, 2'b10);
      chk("rsp_top", rsp_top, e_top);
      chk("rsp_n", rsp_n, e_n);
      chk("rsp_flags", {rsp_ok, rsp_empty, rsp_full, rsp_timeout}, {e_ok, e_empty, e_full, e_to});
      if (i < hold) tick();
    end
    if (e_ok) begin if (op) ref_pop++; else ref_push++; end else ref_err++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("release", {rsp_valid, cmd_ready, rsp_ok, rsp_empty, rsp_full, rsp_timeout}, 6'b010000);
  endtask

  initial begin
    do_reset(3);
    chk("reset_out", {cmd_ready, hp_start, rsp_valid, rsp_ok, rsp_empty, rsp_full, rsp_timeout}, 7'b1000000);
    chk("reset_top", rsp_top, 0);
    send(1, 0, 0, 0, 0, 0);
    send(0, 5, 1, 0, 0, 0);
    send(0, 9, 0, 0, 0, 1);
    send(0, 3, 3, 0, 0, 0);
    hp_done = 1'b1;
    tick();
    hp_done = 1'b0;
    tick();
    chk("stray_done", {cmd_ready, rsp_valid, hp_start}, 3'b100);
    send(0, 77, 0, 1, 0, 0);
    send(1, 0, 2, 0, 0, 10);
    send(0, 11, 0, 0, 1, 0);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = 42;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_cnt = 0; ref_push = 0; ref_pop = 0; ref_err = 0;
    eng_q.delete();
    chk("midreset", {cmd_ready, rsp_valid, hp_start}, 3'b100);
    hp_done = 1'b1;
    tick();
    hp_done = 1'b0;
    repeat (4) begin
      tick();
      chk("midreset_norsp", rsp_valid, 0);
    end
    send(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 120; i++)
      send(i < 60 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 6), $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2));
    do_reset(2);
    send(1, 0, 0, 0, 0, 0);
    send(0, 4, 1, 0, 0, 0);
    send(0, 8, 0, 0, 0, 0);
    send(0, 2, 2, 0, 0, 0);
    send(1, 0, 1, 0, 0, 0);
`ifdef HEAP_HOST_STATS_EN
    chk("stat_push", stat_push, ref_push);
    chk("stat_pop", stat_pop, ref_pop);
    chk("stat_err", stat_err, ref_err);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
